// File: rtl/reg_file_sb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | reg_file_sb: integer register file with write-through bypass and a          |
// | per-register in-flight write scoreboard for RAW/WAW hazard tracking.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module reg_file_sb #(
  parameter int          XLEN    = 32,
  parameter int          AW      = 5,
  parameter int          PEND_W  = 2,
  parameter int          SP_IDX  = 2,
  parameter int unsigned SP_INIT = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_rs1_data,
  output logic [XLEN-1:0] read_rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_full,
  input  logic            write_reg,
  input  logic [AW-1:0]   target_reg,
  input  logic [XLEN-1:0] write_rd_data,
  input  logic            flush,
  output logic [AW:0]     pending_count
);

  localparam int              c_NREGS   = 2**AW;
  localparam logic [PEND_W-1:0] c_CNT_MAX = '1;
  localparam logic [PEND_W-1:0] c_ONE     = PEND_W'(1);

  logic [XLEN-1:0]   r_regs    [c_NREGS];
  logic [PEND_W-1:0] r_cnt     [c_NREGS];
  logic [PEND_W-1:0] w_cnt_nxt [c_NREGS];
  logic [AW:0]       w_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      if (write_reg && (target_reg != '0)) begin
        r_regs[target_reg] <= write_rd_data;
      end
      for (int i = 1; i < c_NREGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Simultaneous inc and dec cancel; a saturated counter drops the issue.
  always_comb begin
    for (int i = 0; i < c_NREGS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
    end
    for (int i = 1; i < c_NREGS; i++) begin
      if (flush) begin
        w_cnt_nxt[i] = '0;
      end else begin
        case ({issue_valid && (issue_rd == AW'(i)) && (r_cnt[i] != c_CNT_MAX),
               write_reg && (target_reg == AW'(i)) && (r_cnt[i] != '0)})
          2'b10:   w_cnt_nxt[i] = r_cnt[i] + c_ONE;
          2'b01:   w_cnt_nxt[i] = r_cnt[i] - c_ONE;
          default: w_cnt_nxt[i] = r_cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 1; i < c_NREGS; i++) begin
      w_pend = w_pend + {{AW{1'b0}}, (r_cnt[i] != '0)};
    end
  end

  assign pending_count = w_pend;

  always_comb begin
    read_rs1_data = r_regs[rs1];
    if (rs1 == '0) begin
      read_rs1_data = '0;
    end else if (write_reg && (target_reg == rs1)) begin
      read_rs1_data = write_rd_data;
    end
    read_rs2_data = r_regs[rs2];
    if (rs2 == '0) begin
      read_rs2_data = '0;
    end else if (write_reg && (target_reg == rs2)) begin
      read_rs2_data = write_rd_data;
    end
  end

  // Busy drops early when the last outstanding write is being bypassed now.
  assign rs1_busy = (rs1 != '0) && (r_cnt[rs1] != '0) &&
                    !(write_reg && (target_reg == rs1) && (r_cnt[rs1] == c_ONE));
  assign rs2_busy = (rs2 != '0) && (r_cnt[rs2] != '0) &&
                    !(write_reg && (target_reg == rs2) && (r_cnt[rs2] == c_ONE));

  assign issue_full = (issue_rd != '0) && (r_cnt[issue_rd] == c_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_reg_file_sb: directed and random stimulus against a behavioural model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;
  localparam int CMAX  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, issue_rd, target_reg;
  logic [XLEN-1:0] read_rs1_data, read_rs2_data, write_rd_data;
  logic            rs1_busy, rs2_busy, issue_valid, issue_full, write_reg, flush;
  logic [AW:0]     pending_count;

  reg_file_sb #(.XLEN(XLEN), .AW(AW), .PEND_W(2), .SP_IDX(2), .SP_INIT(128)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .read_rs1_data(read_rs1_data), .read_rs2_data(read_rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_full(issue_full),
    .write_reg(write_reg), .target_reg(target_reg), .write_rd_data(write_rd_data),
    .flush(flush), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int unsigned mregs [NREGS];
  int          mcnt  [NREGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = 0;
      mcnt[i]  = 0;
    end
    mregs[2] = 128;
  endtask

  function automatic int unsigned exp_rd(input int a);
    if (a == 0) return 0;
    if (write_reg && int'(target_reg) == a) return write_rd_data;
    return mregs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0 || mcnt[a] == 0) return 1'b0;
    return !(write_reg && int'(target_reg) == a && mcnt[a] == 1);
  endfunction

  function automatic int exp_pend();
    int n = 0;
    for (int i = 1; i < NREGS; i++) if (mcnt[i] != 0) n++;
    return n;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".rd1"},  read_rs1_data, exp_rd(int'(rs1)));
    chk({tag, ".rd2"},  read_rs2_data, exp_rd(int'(rs2)));
    chk({tag, ".b1"},   rs1_busy, exp_busy(int'(rs1)));
    chk({tag, ".b2"},   rs2_busy, exp_busy(int'(rs2)));
    chk({tag, ".full"}, issue_full, (issue_rd != 0) && mcnt[issue_rd] == CMAX);
    chk({tag, ".pend"}, pending_count, exp_pend());
  endtask

  task automatic model_update();
    int ir = int'(issue_rd);
    int tr = int'(target_reg);
    if (write_reg && tr != 0) mregs[tr] = write_rd_data;
    for (int r = 1; r < NREGS; r++) begin
      if (flush) mcnt[r] = 0;
      else mcnt[r] = mcnt[r] + int'(issue_valid && ir == r && mcnt[r] < CMAX)
                              - int'(write_reg && tr == r && mcnt[r] > 0);
    end
  endtask

  // Inputs are set by the caller just after a rising edge; check, then clock.
  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; write_reg = 0; target_reg = 0;
    write_rd_data = 0; flush = 0;
  endtask

  task automatic drive(input bit iv, input int ird, input bit wr, input int tr,
                       input int unsigned wd, input bit fl, input int a1, input int a2);
    issue_valid = iv; issue_rd = AW'(ird); write_reg = wr; target_reg = AW'(tr);
    write_rd_data = wd; flush = fl; rs1 = AW'(a1); rs2 = AW'(a2);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs1 = 0; rs2 = 0;
    model_reset();
    // Reset state before any clock edge matters.
    #1;
    for (int a = 0; a < NREGS; a++) begin
      rs1 = AW'(a);
      rs2 = AW'(NREGS - 1 - a);
      #1;
      chk("reset.rd1", read_rs1_data, (a == 2) ? 128 : 0);
      chk("reset.b1", rs1_busy, 1'b0);
    end
    chk("reset.pend", pending_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass
    drive(0, 0, 1, 5, 32'h11, 0, 5, 0); step("wr5");
    drive(0, 0, 0, 5, 32'hAB, 0, 5, 5); step("nobyp");
    drive(0, 0, 1, 5, 32'hAB, 0, 5, 0); step("byp");
    // RAW
    drive(1, 7, 0, 0, 0, 0, 0, 7);     step("iss7");
    drive(0, 0, 0, 0, 0, 0, 0, 7);     step("raw7");
    drive(0, 0, 1, 7, 32'h55, 0, 0, 7); step("wb7");
    drive(0, 0, 0, 0, 0, 0, 0, 7);     step("post7");
    // WAW and saturation
    for (int k = 0; k < 4; k++) begin
      drive(1, 3, 0, 0, 0, 0, 3, 0); step("iss3");
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 3, 1, 3, 32'h300 + k, 0, 3, 0); step("wb3");
    end
    drive(1, 3, 0, 0, 0, 0, 3, 0);        step("iss3b");
    drive(1, 3, 1, 3, 32'h333, 0, 3, 3);  step("incdec3");
    drive(0, 0, 0, 0, 0, 0, 3, 3);        step("hold3");
    // Flush
    drive(1, 4, 0, 0, 0, 0, 0, 0);        step("iss4");
    drive(1, 6, 0, 0, 0, 0, 0, 0);        step("iss6");
    drive(1, 9, 0, 0, 0, 0, 4, 6);        step("iss9");
    drive(1, 10, 1, 4, 32'h99, 1, 4, 10); step("flush");
    drive(0, 0, 0, 0, 0, 0, 4, 10);       step("postflush");
    // Register 0
    drive(1, 0, 1, 0, 32'hFFFF, 0, 0, 0); step("r0");
    drive(0, 0, 0, 0, 0, 0, 0, 3);        step("r0post");

    // Asynchronous reset between edges
    drive(1, 12, 1, 5, 32'h77, 0, 5, 2);  step("prerst");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // Random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 15) == 0), $urandom_range(0, 7), $urandom_range(0, 7));
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with write-through bypass and a per-register write scoreboard, used by the five-stage pipeline core for operand read in ID and writeback in WB. Each architectural register carries a small in-flight write counter. Decode sets it at issue and writeback clears it, so the block reports read-after-write hazards directly. The counters make multiple outstanding writes to one register (WAW) safe, and a flush input discards all pending state on a pipeline redirect.

## Interface
Parameters
- XLEN, 32, data width of each register
- AW, 5, register address width; NREGS = 2**AW
- PEND_W, 2, width of each per-register in-flight counter; max in-flight per register = 2**PEND_W - 1
- SP_IDX, 2, index of the stack-pointer register
- SP_INIT, 128, reset value of register SP_IDX

Ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- rs1, rs2  in  AW  read addresses
- read_rs1_data, read_rs2_data  out  XLEN  read data, combinational
- rs1_busy, rs2_busy  out  1  operand has an uncompleted in-flight write, combinational
- issue_valid  in  1  mark issue_rd as having a new in-flight write
- issue_rd  in  AW  destination of the issuing instruction
- issue_full  out  1  counter of issue_rd is saturated, combinational
- write_reg  in  1  writeback strobe
- target_reg  in  AW  writeback destination
- write_rd_data  in  XLEN  writeback data
- flush  in  1  clear all in-flight counters
- pending_count  out  AW+1  number of registers with a non-zero counter

## Operation
- Register 0 is hard-wired to zero:
  - Reads return 0 and busy is 0.
  - Writes, issues, and counter changes to register 0 are ignored.
- Read data, per port:
  - Address 0 returns 0.
  - If write_reg=1 and target_reg equals the address, returns write_rd_data (bypass). Bypass is gated by write_reg.
  - Otherwise returns the array contents.
- Busy, per port:
  - Asserted if cnt[rs] != 0.
  - Exception: deasserted when write_reg=1, target_reg==rs and cnt[rs]==1. The last outstanding write is completing and is being bypassed.
- Write: on the edge, if write_reg=1 and target_reg!=0, regs[target_reg] <= write_rd_data. The write occurs regardless of flush or counter value.
- Counter update at the edge, per register r != 0, in priority order:
  - flush=1: cnt[r] <= 0. An issue in the same cycle is dropped.
  - inc (issue_valid, issue_rd==r, cnt[r] not saturated) together with dec (write_reg, target_reg==r, cnt[r]!=0): cnt unchanged.
  - inc only: cnt+1.
  - dec only: cnt-1.
  - Writeback to a register with cnt==0 leaves cnt at 0; no underflow.
  - Issue to a saturated register is ignored. issue_full=1 in that cycle, and decode must stall.
- issue_full is 1 when issue_rd!=0 and cnt[issue_rd]==2**PEND_W-1. It does not account for a same-cycle writeback.
- pending_count is the population count of non-zero counters from current state. It is a function of registered state only.

## Timing
- Reset (async, immediate):
  - All regs are 0 except regs[SP_IDX]=SP_INIT.
  - All counters are 0, so pending_count=0, busy=0 and issue_full=0.
  - Read data reflects the reset array immediately.
- A reset asserted mid-operation discards all writes and counters without waiting for a clock edge.
- Read latency is 0 cycles; data written at edge N is visible from the array after edge N, and through bypass during cycle N.
- Issue at edge N: busy is visible from cycle N+1 for reads of that register.
- Writeback at edge N: busy clears during cycle N for the final write (bypass), and cnt drops after edge N.

## Test plan
- Reset: assert rst with no clock -> all reads 0 except rs1=2 reads 128. pending_count=0, busy=0.
- Bypass: regs[5]=0x11, write_reg=1, target_reg=5, data=0xAB, rs1=5 -> read_rs1_data=0xAB in the same cycle. With write_reg=0 and target_reg=5 -> 0x11.
- RAW: issue rd=7 -> next cycle rs2=7 gives rs2_busy=1 and pending_count=1. Writeback to 7 with data 0x55 -> rs2_busy=0 and data 0x55 the same cycle, cnt=0 after the edge.
- WAW and saturation (PEND_W=2): issue rd=3 three times -> issue_full=1 on a fourth issue, which is ignored.
  - Writeback ×2 -> busy stays 1.
  - Third writeback -> busy=0.
  - Simultaneous issue and writeback to 3 -> cnt unchanged.
- Flush: issue rd=4, 6, 9 -> pending_count=3. Flush with a same-cycle issue rd=10 and writeback 4=0x99 -> after the edge pending_count=0, regs[4]=0x99, rd 10 not pending.
- Register 0: issue rd=0 and writeback 0=0xFFFF -> read 0, busy 0, pending_count unchanged.
